// File: rtl/ip_rx_csum_check_if.sv
// RX byte-stream bundle feeding the IPv4 header checksum checker.
// master drives the stream, slave consumes it.
interface ip_rx_csum_check_if;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] in_data;

  modport master (output in_valid, output in_sop, output in_eop, output in_data);
  modport slave  (input  in_valid, input  in_sop, input  in_eop, input  in_data);
endinterface

// File: rtl/ip_rx_csum_check.sv
// Byte-serial IPv4 header checksum verifier on the RX stream; one verdict pulse per packet.
// Optional saturating error counter enabled by defining RX_CSUM_ERR_CNT_EN.
module ip_rx_csum_check #(
  parameter int unsigned MIN_IHL   = 5,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ip_rx_csum_check_if.slave    rx,
  output logic                 hdr_done,
  output logic                 hdr_ok,
  output logic [1:0]           hdr_err,
  output logic [3:0]           ihl_out,
  output logic [15:0]          csum_out,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 17;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_TRUNC = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_CHECK, S_SKIP} state_t;

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic             eop_seen, eop_seen_d;
  logic             done_d, ok_d;
  logic [1:0]       err_d;
  logic [3:0]       ihl_d;
  logic [15:0]      csum_d;

  logic             byte_in, sop_in, eop_in, b0_bad;
  logic [15:0]      term, fold;
  logic [ACC_W-1:0] acc_wrap, acc_sum;
  logic [CNT_W-1:0] last_idx;

  assign byte_in = rx.in_valid;
  assign sop_in  = rx.in_valid & rx.in_sop;
  assign eop_in  = rx.in_valid & rx.in_eop;
  assign b0_bad  = (rx.in_data[7:4] != 4'h4) || (rx.in_data[3:0] < 4'(MIN_IHL));

  // Even byte index is the high half of a big-endian word; carry wraps around before the next add.
  assign term     = byte_cnt[0] ? {8'h00, rx.in_data} : {rx.in_data, 8'h00};
  assign acc_wrap = acc[16] ? (ACC_W'(acc[15:0]) + ACC_W'(1)) : acc;
  assign acc_sum  = acc_wrap + ACC_W'(term);
  assign fold     = acc[15:0] + 16'(acc[16]);
  assign last_idx = {ihl_out - 4'd1, 2'b11};

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    byte_cnt_d = byte_cnt;
    eop_seen_d = eop_seen;
    ihl_d      = ihl_out;
    csum_d     = csum_out;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    err_d      = ERR_NONE;

    if (sop_in) begin
      // A sop in any state restarts parsing; an unfinished packet is dropped silently
      acc_d      = ACC_W'({rx.in_data, 8'h00});
      byte_cnt_d = CNT_W'(1);
      eop_seen_d = 1'b0;
      if (b0_bad) begin
        done_d  = 1'b1;
        err_d   = ERR_FMT;
        state_d = eop_in ? S_IDLE : S_SKIP;
      end else begin
        ihl_d = rx.in_data[3:0];
        if (eop_in) begin
          done_d  = 1'b1;
          err_d   = ERR_TRUNC;
          state_d = S_IDLE;
        end else begin
          state_d = S_HDR;
        end
      end
    end else begin
      case (state)
        S_HDR: begin
          if (byte_in) begin
            acc_d      = acc_sum;
            byte_cnt_d = byte_cnt + CNT_W'(1);
            if (byte_cnt == last_idx) begin
              state_d    = S_CHECK;
              eop_seen_d = eop_in;
            end else if (eop_in) begin
              done_d  = 1'b1;
              err_d   = ERR_TRUNC;
              state_d = S_IDLE;
            end
          end
        end
        S_CHECK: begin
          csum_d  = fold;
          done_d  = 1'b1;
          ok_d    = (fold == 16'hFFFF);
          err_d   = (fold == 16'hFFFF) ? ERR_NONE : ERR_CSUM;
          state_d = (eop_seen || eop_in) ? S_IDLE : S_SKIP;
        end
        S_SKIP: begin
          if (eop_in) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      byte_cnt <= '0;
      eop_seen <= 1'b0;
      hdr_done <= 1'b0;
      hdr_ok   <= 1'b0;
      hdr_err  <= ERR_NONE;
      ihl_out  <= '0;
      csum_out <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      byte_cnt <= byte_cnt_d;
      eop_seen <= eop_seen_d;
      hdr_done <= done_d;
      hdr_ok   <= ok_d;
      hdr_err  <= err_d;
      ihl_out  <= ihl_d;
      csum_out <= csum_d;
      busy     <= (state_d != S_IDLE);
    end
  end

`ifdef RX_CSUM_ERR_CNT_EN
  // Saturating count of failed verdicts, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (done_d && !ok_d && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ip_rx_csum_check.sv
// Directed + randomized bench for ip_rx_csum_check against a packet-level checksum model.
module tb_ip_rx_csum_check;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        ok;
    logic [1:0]  err;
    logic [15:0] csum;
    logic [3:0]  ihl;
    logic [15:0] cnt;
    logic [31:0] cyc;
  } vd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_done, hdr_ok, busy;
  logic [1:0]  hdr_err;
  logic [3:0]  ihl_out;
  logic [15:0] csum_out, err_cnt;

  ip_rx_csum_check_if rx();

  ip_rx_csum_check #(.MIN_IHL(5), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .hdr_done(hdr_done), .hdr_ok(hdr_ok), .hdr_err(hdr_err),
    .ihl_out(ihl_out), .csum_out(csum_out), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nerr = 0, ncyc = 0, inv_bad = 0;
  vd_t         obs_q[$], exp_q[$];
  logic [31:0] acc_cyc[$];
  logic [3:0]  m_ihl;
  logic [15:0] m_csum, m_cnt;

  // Record every verdict pulse with the falling-edge index it was seen on
  always @(negedge clk) begin
    ncyc++;
    if (hdr_done === 1'b1)
      obs_q.push_back('{ok: hdr_ok, err: hdr_err, csum: csum_out, ihl: ihl_out, cnt: err_cnt, cyc: 32'(ncyc)});
    else if (hdr_ok !== 1'b0 || hdr_err !== 2'd0)
      inv_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] oc_sum(input bq_t b, input int n);
    int unsigned s = 0;
    for (int k = 0; k < n; k++)
      s += (k % 2 == 0) ? (32'(b[k]) << 8) : 32'(b[k]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  function automatic bq_t head(input bq_t b, input int n);
    bq_t r;
    for (int k = 0; k < n; k++) r.push_back(b[k]);
    return r;
  endfunction

  function automatic bq_t make_hdr(input int ihl);
    bq_t b;
    logic [15:0] c;
    b.push_back({4'h4, 4'(ihl)});
    for (int k = 1; k < ihl * 4; k++) b.push_back(8'($urandom));
    b[10] = 8'h00;
    b[11] = 8'h00;
    c = ~oc_sum(b, ihl * 4);
    b[10] = c[15:8];
    b[11] = c[7:0];
    return b;
  endfunction

  task automatic bump_cnt();
`ifdef RX_CSUM_ERR_CNT_EN
    if (m_cnt != 16'hFFFF) m_cnt++;
`endif
  endtask

  // gap: percent chance of an idle cycle before each byte; 100 means exactly one idle per byte
  task automatic send(input bq_t b, input bit eop, input int gap);
    acc_cyc.delete();
    foreach (b[i]) begin
      if (gap >= 100) @(negedge clk);
      else while ($urandom_range(0, 99) < gap) @(negedge clk);
      rx.in_valid = 1'b1;
      rx.in_sop   = (i == 0);
      rx.in_eop   = eop && (i == b.size() - 1);
      rx.in_data  = b[i];
      @(posedge clk);
      acc_cyc.push_back(32'(ncyc + 1));
      @(negedge clk);
      rx.in_valid = 1'b0;
      rx.in_sop   = 1'b0;
      rx.in_eop   = 1'b0;
    end
  endtask

  // Packet-level expectation: format error, truncation, or checksum verdict
  task automatic model(input bq_t b, input bit eop);
    vd_t v;
    int  hl;
    logic [15:0] s;
    if (b[0][7:4] != 4'h4 || b[0][3:0] < 4'd5) begin
      bump_cnt();
      v = '{ok: 1'b0, err: 2'd1, csum: m_csum, ihl: m_ihl, cnt: m_cnt, cyc: acc_cyc[0]};
      exp_q.push_back(v);
    end else begin
      m_ihl = b[0][3:0];
      hl = int'(m_ihl) * 4;
      if (b.size() < hl) begin
        if (eop) begin
          bump_cnt();
          v = '{ok: 1'b0, err: 2'd2, csum: m_csum, ihl: m_ihl, cnt: m_cnt, cyc: acc_cyc[b.size() - 1]};
          exp_q.push_back(v);
        end
      end else begin
        s = oc_sum(b, hl);
        m_csum = s;
        if (s != 16'hFFFF) bump_cnt();
        v = '{ok: (s == 16'hFFFF), err: (s == 16'hFFFF) ? 2'd0 : 2'd3, csum: s, ihl: m_ihl,
              cnt: m_cnt, cyc: acc_cyc[hl - 1] + 32'd1};
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_ok"},     32'(obs_q[i].ok),   32'(exp_q[i].ok));
      chk({tag, "_err"},    32'(obs_q[i].err),  32'(exp_q[i].err));
      chk({tag, "_csum"},   32'(obs_q[i].csum), 32'(exp_q[i].csum));
      chk({tag, "_ihl"},    32'(obs_q[i].ihl),  32'(exp_q[i].ihl));
      chk({tag, "_errcnt"}, 32'(obs_q[i].cnt),  32'(exp_q[i].cnt));
      chk({tag, "_cycle"},  obs_q[i].cyc,       exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input bq_t b, input bit eop, input int gap, input string tag);
    send(b, eop, gap);
    model(b, eop);
    repeat (3) @(negedge clk);
    compare(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},   32'(hdr_done), 32'd0);
    chk({tag, "_ok"},     32'(hdr_ok),   32'd0);
    chk({tag, "_err"},    32'(hdr_err),  32'd0);
    chk({tag, "_ihl"},    32'(ihl_out),  32'd0);
    chk({tag, "_csum"},   32'(csum_out), 32'd0);
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt),  32'd0);
  endtask

  bq_t tp, tp_pkt, pk, h;
  int  kind, ih, gap, n;
  logic [7:0] b0;

  initial begin
    rx.in_valid = 1'b0;
    rx.in_sop   = 1'b0;
    rx.in_eop   = 1'b0;
    rx.in_data  = 8'h00;
    rst_n  = 1'b0;
    m_ihl  = '0;
    m_csum = '0;
    m_cnt  = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    tp = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
           8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    tp_pkt = tp;
    tp_pkt.push_back(8'hDE); tp_pkt.push_back(8'hAD);
    tp_pkt.push_back(8'hBE); tp_pkt.push_back(8'hEF);

    run(tp_pkt, 1'b1, 0, "good");
    chk("good_csum_const", 32'(csum_out), 32'h0000FFFF);
    chk("good_ihl_const",  32'(ihl_out),  32'd5);

    pk = tp_pkt;
    pk[11] = 8'h62;
    run(pk, 1'b1, 0, "bad_csum");

    pk = '{8'h44, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00};
    run(pk, 1'b1, 0, "bad_ihl");

    run(head(tp, 10), 1'b1, 0, "trunc9");
    run(tp_pkt, 1'b1, 100, "gappy");

    send(head(tp, 7), 1'b0, 0);
    model(head(tp, 7), 1'b0);
    run(tp_pkt, 1'b1, 0, "resop");

    // Reset asserted between clock edges in the middle of a header
    send(head(tp, 8), 1'b0, 0);
    chk("busy_mid_hdr", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n  = 1'b1;
    m_ihl  = '0;
    m_csum = '0;
    m_cnt  = '0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(obs_q.size()), 32'd0);
    obs_q.delete();

    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 5);
      ih   = $urandom_range(5, 15);
      gap  = $urandom_range(0, 40);
      h    = make_hdr(ih);
      case (kind)
        0, 1: begin
          pk = h;
          repeat ($urandom_range(0, 6)) pk.push_back(8'($urandom));
          run(pk, 1'b1, gap, "rnd_good");
        end
        2: begin
          n = $urandom_range(1, ih * 4 - 1);
          h[n] = h[n] ^ 8'(1 << $urandom_range(0, 7));
          pk = h;
          repeat ($urandom_range(0, 6)) pk.push_back(8'($urandom));
          run(pk, 1'b1, gap, "rnd_bad_csum");
        end
        3: begin
          if ($urandom_range(0, 1) == 1) b0 = {4'h4, 4'($urandom_range(0, 4))};
          else                           b0 = {4'($urandom_range(5, 15)), 4'($urandom)};
          pk = '{b0};
          repeat ($urandom_range(1, 8)) pk.push_back(8'($urandom));
          run(pk, 1'b1, gap, "rnd_bad_b0");
        end
        4: run(head(h, $urandom_range(1, ih * 4 - 1)), 1'b1, gap, "rnd_trunc");
        default: begin
          pk = h;
          repeat (4) pk.push_back(8'($urandom));
          if ($urandom_range(0, 1) == 1) n = $urandom_range(1, ih * 4 - 1);
          else                           n = ih * 4 + $urandom_range(1, 4);
          send(head(pk, n), 1'b0, gap);
          model(head(pk, n), 1'b0);
          run(make_hdr($urandom_range(5, 15)), 1'b1, gap, "rnd_abort");
        end
      endcase
    end

    chk("idle_outputs_zero", 32'(inv_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
